seg7_scan_driver: RTL and testbench

- Downstream display stage for the adder datapath. Takes a 16-bit value as four hex nibbles and time-multiplexes it onto a 4-digit common-anode seven-segment display.
- Outputs are active-low segments (a..g), an active-low decimal point and active-low anodes.
- New values are double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new digits.
- Ghosting is suppressed by blanking the anodes at the start of each digit slot.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/hex_to_seg7.sv | 14 +
 rtl/seg7_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Purpose: shared constants for the seven-segment display path (blanking levels, hex glyph table).
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

  // Active-low "everything dark" levels for the segment and anode buses.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Hex glyphs, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose: decode one hex nibble to an active-low seven-segment glyph.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: nibble - 4-bit hex value; seg - {g,f,e,d,c,b,a}, active-low.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplex a 16-bit hex value onto a 4-digit common-anode display, frame-synchronous updates.
// Latency: outputs registered one cycle after the scan counter state; loads show from the next frame.
// Backpressure: none; load is always accepted, later loads overwrite an unapplied one (pending flags it).
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   data_in, dp_in - value and decimal points captured on the load strobe
//   blank_mask     - live per-digit force-off
//   pending        - a captured value is waiting for the frame boundary
//   seg, dp, an    - active-low segment, decimal point and anode drives
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic        load,
  output logic        pending,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          slot_tick;
  logic          frame_tick;

  logic [15:0]   disp_dat;
  logic [3:0]    disp_dp;
  logic [15:0]   shadow_dat;
  logic [3:0]    shadow_dp;

  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign slot_tick  = (presc == PW'(CLK_DIV - 1));
  assign frame_tick = slot_tick && (idx == 2'd3);

  // Scan counters: prescaler sets the slot length, idx picks the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (slot_tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Double buffer. The display register only moves on frame_tick so a frame
  // never mixes digits from two values. A load coinciding with the boundary
  // bypasses the shadow and lands directly, so it is never left pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_dat   <= '0;
      disp_dp    <= '0;
      shadow_dat <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (frame_tick) begin
      if (load) begin
        disp_dat   <= data_in;
        disp_dp    <= dp_in;
        shadow_dat <= data_in;
        shadow_dp  <= dp_in;
      end else if (pending) begin
        disp_dat <= shadow_dat;
        disp_dp  <= shadow_dp;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow_dat <= data_in;
      shadow_dp  <= dp_in;
      pending    <= 1'b1;
    end
  end

  assign cur_nib = disp_dat[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Next output values. The first BLANK_CYCLES of each slot keep every anode
  // off so the previous digit's segments cannot ghost onto the new anode.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (presc >= PW'(BLANK_CYCLES)) begin
      seg_nxt = cur_seg;
      dp_nxt  = ~disp_dp[idx];
      if (!blank_mask[idx]) begin
        an_nxt = ~(4'b0001 << idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: directed bench for seg7_scan_driver with CLK_DIV=8, BLANK_CYCLES=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        load;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_driver #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .load       (load),
    .pending    (pending),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run ncyc cycles of a frame that starts at slot 0 phase 0, checking every
  // registered output. s0..s3 are the glyphs this frame must show, dpn is the
  // active-low dp per digit, bm the blank mask applied for the frame. Loads are
  // driven so they are sampled on edge ld_at / ld2_at of the frame (edge 31 is
  // the frame boundary).
  task automatic run_frame(input string tag,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpn, input logic [3:0] bm,
                           input int ld_at, input logic [15:0] ld_dat, input logic [3:0] ld_dp,
                           input int ld2_at, input logic [15:0] ld2_dat,
                           input int ncyc);
    logic [6:0] segs [4];
    logic [3:0] one;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    logic       pend_e;
    int         ph;
    int         d;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    one = 4'b0001;
    blank_mask = bm;
    for (int i = 0; i < ncyc; i++) begin
      load    = (i == ld_at) || (i == ld2_at);
      data_in = (i == ld2_at) ? ld2_dat : ld_dat;
      dp_in   = (i == ld2_at) ? 4'b0000 : ld_dp;
      @(posedge clk);
      #1;
      load = 1'b0;
      ph = i % 8;
      d  = i / 8;
      if (ph < 2) begin
        an_e  = 4'b1111;
        seg_e = 7'b1111111;
        dp_e  = 1'b1;
      end else begin
        an_e  = bm[d] ? 4'b1111 : ~(one << d);
        seg_e = segs[d];
        dp_e  = dpn[d];
      end
      pend_e = (ld_at >= 0) && (ld_at < 31) && (i >= ld_at) && (i < 31);
      check($sformatf("%s c%0d an", tag, i), 16'(an), 16'(an_e));
      check($sformatf("%s c%0d seg", tag, i), 16'(seg), 16'(seg_e));
      check($sformatf("%s c%0d dp", tag, i), 16'(dp), 16'(dp_e));
      check($sformatf("%s c%0d pending", tag, i), 16'(pending), 16'(pend_e));
    end
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    data_in    = 16'h0000;
    dp_in      = 4'b0000;
    blank_mask = 4'b0000;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("reset an", 16'(an), 16'h000F);
    check("reset seg", 16'(seg), 16'h007F);
    check("reset dp", 16'(dp), 16'h0001);
    check("reset pending", 16'(pending), 16'h0000);
    rst = 1'b0;

    // Idle frame after reset: zeros everywhere.
    run_frame("f0_idle", G0, G0, G0, G0, 4'b1111, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 32);
    // Mid-frame load of 3A7F; display stays at zero until the boundary.
    run_frame("f1_load", G0, G0, G0, G0, 4'b1111, 4'b0000, 12, 16'h3A7F, 4'b0100, -1, 16'h0000, 32);
    // 3A7F shows, dp only on digit 2; two loads this frame, last one wins.
    run_frame("f2_3a7f", GF, G7, GA, G3, 4'b1011, 4'b0000, 4, 16'h1111, 4'b0000, 20, 16'h2222, 32);
    // 2222 shows; BEEF loaded exactly on the frame boundary edge.
    run_frame("f3_2222", G2, G2, G2, G2, 4'b1111, 4'b0000, 31, 16'hBEEF, 4'b0000, -1, 16'h0000, 32);
    // BEEF shows immediately; queue 0123.
    run_frame("f4_beef", GF, GE, GE, GB, 4'b1111, 4'b0000, 10, 16'h0123, 4'b0000, -1, 16'h0000, 32);
    // 0123 with digits 1 and 3 masked; load 5555 then reset mid slot 1.
    run_frame("f5_mask", G3, G2, G1, G0, 4'b1111, 4'b1010, 3, 16'h5555, 4'b1111, -1, 16'h0000, 13);

    rst     = 1'b1;
    load    = 1'b1;
    data_in = 16'h9999;
    dp_in   = 4'b1111;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    check("rst_mid an", 16'(an), 16'h000F);
    check("rst_mid seg", 16'(seg), 16'h007F);
    check("rst_mid dp", 16'(dp), 16'h0001);
    check("rst_mid pending", 16'(pending), 16'h0000);

    // Restarted frame: pending value and the load under reset are gone.
    run_frame("f6_after_rst", G0, G0, G0, G0, 4'b1111, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 32);
    run_frame("f7_after_rst", G0, G0, G0, G0, 4'b1111, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
